// File: rtl/text_line_prefetch.sv
// Glyph-ROM line prefetcher for the text pages: fetches one glyph row per string character into
// a ping-pong line buffer ahead of each scanline. Define TEXT_SCALE2_EN for 2x vertical scaling.
module text_line_prefetch #(
    parameter int MAX_CHARS = 16,
    parameter int CODE_W    = 5,
    parameter int GLYPH_W   = 16,
    parameter int GLYPH_H   = 16,
    localparam int IDX_W    = $clog2(MAX_CHARS)
) (
    input  logic               vga_clk,
    input  logic               sys_rst,
    input  logic               line_start,
    input  logic [9:0]         next_y,
    input  logic [9:0]         str_top,
    input  logic [4:0]         str_len,
    input  logic               code_wr_en,
    input  logic [IDX_W-1:0]   code_wr_addr,
    input  logic [CODE_W-1:0]  code_wr_data,
    output logic               rom_rd,
    output logic [CODE_W-1:0]  rom_code,
    output logic [3:0]         rom_row,
    input  logic [GLYPH_W-1:0] rom_data,
    input  logic [IDX_W-1:0]   pix_idx,
    input  logic [3:0]         pix_col,
    output logic               pix_bit,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state_reg;
    logic [CODE_W-1:0]  code_mem [MAX_CHARS];
    logic [GLYPH_W-1:0] line_mem [2*MAX_CHARS];
    logic               disp_bank_reg;
    logic [1:0]         bank_active_reg;
    logic [4:0]         bank_len_reg [2];
    logic [IDX_W-1:0]   fetch_idx_reg;
    logic [4:0]         fetch_len_reg;
    logic               wb_valid_reg;
    logic               wb_bank_reg;
    logic [IDX_W-1:0]   wb_idx_reg;

    logic [4:0]         len_clamped;
    logic [9:0]         row_diff;
    logic               in_band;
    logic [3:0]         fetch_row;
    logic               start_fetch;
    logic               last_issue;
    logic [IDX_W-1:0]   code_sel_idx;
    logic [CODE_W-1:0]  code_sel;
    logic [GLYPH_W-1:0] disp_word;
    logic [3:0]         col_sel;

    assign len_clamped = (str_len > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : str_len;
    assign row_diff    = next_y - str_top;

`ifdef TEXT_SCALE2_EN
    assign in_band   = row_diff < 10'(2*GLYPH_H);
    assign fetch_row = row_diff[4:1];
`else
    assign in_band   = row_diff < 10'(GLYPH_H);
    assign fetch_row = row_diff[3:0];
`endif

    assign start_fetch = in_band && (len_clamped != 5'd0);
    assign last_issue  = ({1'b0, fetch_idx_reg} == (fetch_len_reg - 5'd1));

    // A write landing on the very character about to be presented is forwarded,
    // so not-yet-fetched characters always see the newest code.
    always_comb begin
        code_sel_idx = line_start ? '0 : fetch_idx_reg + 1'b1;
        code_sel     = code_mem[code_sel_idx];
        if (code_wr_en && (code_wr_addr == code_sel_idx))
            code_sel = code_wr_data;
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < MAX_CHARS; i++)
                code_mem[i] <= '0;
        end else if (code_wr_en) begin
            code_mem[code_wr_addr] <= code_wr_data;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg       <= IDLE;
            disp_bank_reg   <= 1'b0;
            bank_active_reg <= 2'b00;
            bank_len_reg[0] <= 5'd0;
            bank_len_reg[1] <= 5'd0;
            fetch_idx_reg   <= '0;
            fetch_len_reg   <= 5'd0;
            wb_valid_reg    <= 1'b0;
            wb_bank_reg     <= 1'b0;
            wb_idx_reg      <= '0;
            rom_rd          <= 1'b0;
            rom_code        <= '0;
            rom_row         <= 4'd0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            // Each issued read returns next cycle into the bank that was filling when it was issued.
            wb_valid_reg <= rom_rd;
            wb_bank_reg  <= ~disp_bank_reg;
            wb_idx_reg   <= fetch_idx_reg;

            if (line_start) begin
                disp_bank_reg <= ~disp_bank_reg;
                if (state_reg != IDLE)
                    overrun <= 1'b1;
                // The old display bank becomes the new fill bank.
                if (start_fetch) begin
                    bank_active_reg[disp_bank_reg] <= 1'b1;
                    bank_len_reg[disp_bank_reg]    <= len_clamped;
                    fetch_len_reg <= len_clamped;
                    fetch_idx_reg <= '0;
                    rom_rd        <= 1'b1;
                    rom_code      <= code_sel;
                    rom_row       <= fetch_row;
                    busy          <= 1'b1;
                    state_reg     <= FETCH;
                end else begin
                    bank_active_reg[disp_bank_reg] <= 1'b0;
                    rom_rd    <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            end else begin
                case (state_reg)
                    FETCH: begin
                        if (last_issue) begin
                            rom_rd    <= 1'b0;
                            state_reg <= DRAIN;
                        end else begin
                            fetch_idx_reg <= fetch_idx_reg + 1'b1;
                            rom_code      <= code_sel;
                        end
                    end
                    DRAIN: begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        rom_rd <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (wb_valid_reg)
            line_mem[{wb_bank_reg, wb_idx_reg}] <= rom_data;
    end

    assign disp_word = line_mem[{disp_bank_reg, pix_idx}];
    assign col_sel   = 4'(GLYPH_W - 1) - pix_col;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst)
            pix_bit <= 1'b0;
        else
            pix_bit <= bank_active_reg[disp_bank_reg]
                       && ({1'b0, pix_idx} < bank_len_reg[disp_bank_reg])
                       && disp_word[col_sel];
    end

endmodule
